exu_wbu: RTL and testbench
==========================

Name: exu_wbu

Overview:
- Downstream consumer of the execute unit's result interface: latches one executed instruction per handshake.
- Selects the ALU/BJU/MULDIV result, or issues a load/store to the data-memory port and waits for the response.
- Drives the regfile write port and a one-cycle front-end flush when the execute unit reports a redirect.
- Sits between the execute unit and the regfile/fetch redirect logic.

Parameters:
- XLEN, 64, width of results, addresses, PC and memory data.
- LREG_W, 5, logical register index width.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute beat valid.
- in_ready  out  1  block can accept a beat.
- in_rd  in  LREG_W  destination register.
- in_need_to_wb  in  1  instruction writes rd.
- in_is_bju  in  1  branch/jump; select bju_result.
- in_is_muldiv  in  1  select muldiv_result.
- in_is_load  in  1  load.
- in_is_store  in  1  store.
- in_is_unsigned  in  1  zero-extend load data.
- in_ls_size  in  4  one-hot: [0] byte, [1] half, [2] word, [3] dword.
- in_ls_address  in  XLEN  effective address.
- in_store_data  in  XLEN  store data, right-aligned.
- in_alu_result, in_bju_result, in_muldiv_result  in  XLEN each.
- in_redirect_valid  in  1  redirect from the execute unit.
- in_redirect_target  in  XLEN  redirect target.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_wen  out  1  1 = store.
- mem_req_addr  out  XLEN  8-byte-aligned address (addr[2:0] forced to 0).
- mem_req_wdata  out  XLEN  store data shifted left by 8*addr[2:0].
- mem_req_wmask  out  8  byte mask shifted left by addr[2:0].
- mem_resp_valid  in  1  response (load data or store ack).
- mem_resp_rdata  in  XLEN  load data for the aligned doubleword.
- wb_valid  out  1  regfile write enable.
- wb_rd  out  LREG_W  write index.
- wb_data  out  XLEN  write data.
- flush_valid  out  1  front-end redirect pulse.
- flush_target  out  XLEN  redirect PC.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, all registered outputs 0; in_ready=1 once reset deasserts.
- Reset mid-memory-transaction: return to IDLE and drop the transaction; a later mem_resp_valid seen in IDLE is ignored.
- FSM states: IDLE, MEM_REQ, MEM_WAIT.
- in_ready = (state==IDLE). A beat is accepted when in_valid && in_ready at cycle N; all inputs are captured into internal registers at N.
- Non-memory beat: wb_valid=1 at cycle N+1 for exactly one cycle, only if in_need_to_wb && in_rd!=0.
  - wb_data priority: bju > muldiv > alu.
  - State stays IDLE, so back-to-back beats sustain 1/cycle.
- Memory beat (load or store): state -> MEM_REQ.
  - mem_req_valid=1 from N+1, outputs held stable until mem_req_ready; then -> MEM_WAIT.
  - mem_req_wmask: byte=0x01, half=0x03, word=0x0F, dword=0xFF, each shifted left by addr[2:0].
  - Mask bits past bit 7 are discarded; no misalignment exception.
  - mem_req_wen=1 for a store.
  - in_ready=0 throughout MEM_REQ and MEM_WAIT.
- MEM_WAIT: on mem_resp_valid -> IDLE.
  - Load: wb_valid=1 the following cycle. Data = rdata >> (8*addr[2:0]), truncated to the size, then sign-extended, or zero-extended if in_is_unsigned.
  - Load with rd==0 or !need_to_wb: no write.
  - Store: no write.
  - mem_resp_valid in the same cycle as mem_req_ready is not legal; the responder guarantees at least 1 cycle between them.
- Load and store both set: treat as a load.
- Redirect: for an accepted beat with in_redirect_valid, flush_valid=1 at N+1 for one cycle with flush_target latched.
  - The redirect beat's own writeback (the link register) still occurs.
  - The block does not squash younger beats; upstream handles that.
- wb_valid and flush_valid are pure one-cycle pulses and never repeat for a single beat.

Test Plan:
- ALU beat rd=5, alu_result=0x1234, need_to_wb=1 -> wb_valid at N+1, wb_rd=5, wb_data=0x1234, in_ready stays 1; the same beat with rd=0 -> no wb_valid.
- Jump beat is_bju, bju_result=0x8000_0004, redirect_valid=1, target=0x8000_0100 -> at N+1: wb_data=0x8000_0004, flush_valid=1, flush_target=0x8000_0100, both for one cycle.
- Signed byte load, addr=0x1003, rdata=0x0000_0000_8000_0000, rd=7 -> mem_req_addr=0x1000, wmask=0x08, wen=0; wb_data=0xFFFF_FFFF_FFFF_FF80. Same load with is_unsigned -> 0x80.
- Half store, addr=0x2006, data=0xBEEF, mem_req_ready held 0 for 3 cycles -> mem_req_valid, addr, wdata=0xBEEF_0000_0000_0000 and wmask=0xC0 stable; in_ready=0 until the cycle after mem_resp_valid; no wb_valid.
- Back-to-back: 4 ALU beats on consecutive cycles -> 4 consecutive wb_valid pulses with matching rd/data.
- Reset asserted in MEM_WAIT -> outputs 0 immediately, state IDLE; a stale mem_resp_valid afterwards produces no wb_valid.

Source files
------------

// File: rtl/exu_wbu.sv
// Writeback stage behind the execute unit: selects the result, runs loads/stores
// through the data-memory port, and drives the regfile write and front-end flush pulse.
module exu_wbu #(
  parameter int XLEN   = 64,
  parameter int LREG_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LREG_W-1:0] in_rd,
  input  logic              in_need_to_wb,
  input  logic              in_is_bju,
  input  logic              in_is_muldiv,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic              in_is_unsigned,
  input  logic [3:0]        in_ls_size,
  input  logic [XLEN-1:0]   in_ls_address,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_bju_result,
  input  logic [XLEN-1:0]   in_muldiv_result,
  input  logic              in_redirect_valid,
  input  logic [XLEN-1:0]   in_redirect_target,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata,
  output logic              wb_valid,
  output logic [LREG_W-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              flush_valid,
  output logic [XLEN-1:0]   flush_target
);

  // state    | meaning
  // IDLE     | accepting beats; non-memory results written back next cycle
  // MEM_REQ  | memory request presented, waiting for mem_req_ready
  // MEM_WAIT | request accepted, waiting for mem_resp_valid
  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT} state_t;

  state_t state, state_nxt;

  logic              accept;
  logic              in_is_mem;
  logic [7:0]        mask_base;
  logic [XLEN-1:0]   sel_result;
  logic [XLEN-1:0]   rdata_shifted;
  logic [XLEN-1:0]   load_data;

  logic [LREG_W-1:0] rd_q;
  logic              need_wb_q;
  logic              load_q;
  logic              unsigned_q;
  logic [3:0]        size_q;
  logic [2:0]        off_q;
  logic              wen_q;
  logic [XLEN-1:0]   req_addr_q;
  logic [XLEN-1:0]   req_wdata_q;
  logic [7:0]        req_wmask_q;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign in_is_mem = in_is_load || in_is_store;

  assign mem_req_valid = (state == MEM_REQ);
  assign mem_req_wen   = wen_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;

  always_comb begin
    mask_base = 8'h00;
    if (in_ls_size[3])      mask_base = 8'hFF;
    else if (in_ls_size[2]) mask_base = 8'h0F;
    else if (in_ls_size[1]) mask_base = 8'h03;
    else if (in_ls_size[0]) mask_base = 8'h01;
  end

  always_comb begin
    sel_result = in_alu_result;
    if (in_is_bju)         sel_result = in_bju_result;
    else if (in_is_muldiv) sel_result = in_muldiv_result;
  end

  // Response data covers the aligned doubleword; bring the addressed bytes to bit 0.
  assign rdata_shifted = mem_resp_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data = rdata_shifted;
    if (size_q[3]) begin
      load_data = rdata_shifted;
    end else if (size_q[2]) begin
      load_data = {{(XLEN-32){rdata_shifted[31] & ~unsigned_q}}, rdata_shifted[31:0]};
    end else if (size_q[1]) begin
      load_data = {{(XLEN-16){rdata_shifted[15] & ~unsigned_q}}, rdata_shifted[15:0]};
    end else if (size_q[0]) begin
      load_data = {{(XLEN-8){rdata_shifted[7] & ~unsigned_q}}, rdata_shifted[7:0]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept && in_is_mem) state_nxt = MEM_REQ;
      MEM_REQ:  if (mem_req_ready)       state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_resp_valid)      state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q         <= '0;
      need_wb_q    <= 1'b0;
      load_q       <= 1'b0;
      unsigned_q   <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      wen_q        <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_wmask_q  <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      flush_valid  <= 1'b0;
      flush_target <= '0;
    end else begin
      wb_valid    <= 1'b0;
      flush_valid <= 1'b0;
      if (accept) begin
        rd_q        <= in_rd;
        need_wb_q   <= in_need_to_wb;
        load_q      <= in_is_load;
        unsigned_q  <= in_is_unsigned;
        size_q      <= in_ls_size;
        off_q       <= in_ls_address[2:0];
        // A beat flagged as both load and store is handled as a load.
        wen_q       <= in_is_store && !in_is_load;
        req_addr_q  <= {in_ls_address[XLEN-1:3], 3'b000};
        req_wdata_q <= in_store_data << {in_ls_address[2:0], 3'b000};
        req_wmask_q <= mask_base << in_ls_address[2:0];
        flush_valid <= in_redirect_valid;
        if (in_redirect_valid) flush_target <= in_redirect_target;
        if (!in_is_mem) begin
          wb_valid <= in_need_to_wb && (in_rd != '0);
          wb_rd    <= in_rd;
          wb_data  <= sel_result;
        end
      end else if (state == MEM_WAIT && mem_resp_valid && load_q) begin
        wb_valid <= need_wb_q && (rd_q != '0);
        wb_rd    <= rd_q;
        wb_data  <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_exu_wbu.sv
// Bench for exu_wbu: directed scenarios plus randomized beats checked against
// a byte-level reference model of selection, masking and load extension.
module tb_exu_wbu;
  localparam int XLEN = 64;
  localparam int LREG_W = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [LREG_W-1:0] in_rd;
  logic              in_need_to_wb, in_is_bju, in_is_muldiv, in_is_load, in_is_store, in_is_unsigned;
  logic [3:0]        in_ls_size;
  logic [XLEN-1:0]   in_ls_address, in_store_data, in_alu_result, in_bju_result, in_muldiv_result;
  logic              in_redirect_valid;
  logic [XLEN-1:0]   in_redirect_target;
  logic              mem_req_valid, mem_req_ready, mem_req_wen;
  logic [XLEN-1:0]   mem_req_addr, mem_req_wdata;
  logic [7:0]        mem_req_wmask;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_resp_rdata;
  logic              wb_valid;
  logic [LREG_W-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              flush_valid;
  logic [XLEN-1:0]   flush_target;

  int n_assert = 0;
  int n_fail = 0;

  exu_wbu #(.XLEN(XLEN), .LREG_W(LREG_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_need_to_wb(in_need_to_wb),
    .in_is_bju(in_is_bju), .in_is_muldiv(in_is_muldiv), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_is_unsigned(in_is_unsigned), .in_ls_size(in_ls_size),
    .in_ls_address(in_ls_address), .in_store_data(in_store_data), .in_alu_result(in_alu_result),
    .in_bju_result(in_bju_result), .in_muldiv_result(in_muldiv_result),
    .in_redirect_valid(in_redirect_valid), .in_redirect_target(in_redirect_target),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush_valid(flush_valid), .flush_target(flush_target)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_beat();
    in_valid = 0; in_rd = '0; in_need_to_wb = 0; in_is_bju = 0; in_is_muldiv = 0;
    in_is_load = 0; in_is_store = 0; in_is_unsigned = 0; in_ls_size = 4'b0001;
    in_ls_address = '0; in_store_data = '0; in_alu_result = '0; in_bju_result = '0;
    in_muldiv_result = '0; in_redirect_valid = 0; in_redirect_target = '0;
  endtask

  function automatic logic [3:0] size_code(int nbytes);
    case (nbytes)
      1: return 4'b0001;
      2: return 4'b0010;
      4: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [7:0] ref_mask(int off, int nbytes);
    logic [7:0] m = '0;
    for (int i = 0; i < nbytes; i++) if (off + i < 8) m[off + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] ref_wdata(int off, logic [63:0] sd);
    logic [63:0] w = '0;
    for (int i = 0; off + i < 8; i++) w[8*(off+i) +: 8] = sd[8*i +: 8];
    return w;
  endfunction

  function automatic logic [63:0] ref_load(logic [63:0] rd, int off, int nbytes, bit uns);
    logic [63:0] r = '0;
    for (int i = 0; i < nbytes; i++) if (off + i < 8) r[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!uns && r[8*nbytes-1])
      for (int i = nbytes; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  // Presents the current beat for one cycle and checks the N+1 results and pulse widths.
  task automatic plain_beat(input bit exp_wb, input logic [63:0] exp_data, input bit exp_fl,
                            input logic [63:0] exp_tgt);
    logic [LREG_W-1:0] rd_s;
    rd_s = in_rd;
    in_valid = 1;
    chk("ready_before_beat", in_ready, 1);
    tick();
    in_valid = 0;
    chk("wb_valid", wb_valid, exp_wb);
    if (exp_wb) begin
      chk("wb_rd", wb_rd, rd_s);
      chk("wb_data", wb_data, exp_data);
    end
    chk("flush_valid", flush_valid, exp_fl);
    if (exp_fl) chk("flush_target", flush_target, exp_tgt);
    chk("ready_after_beat", in_ready, 1);
    tick();
    chk("wb_pulse_end", wb_valid, 0);
    chk("flush_pulse_end", flush_valid, 0);
  endtask

  task automatic mem_beat(input int stall, input int lat, input logic [63:0] rdata,
                          input bit exp_wb, input logic [63:0] exp_data,
                          input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                          input logic [7:0] exp_mask, input bit exp_wen);
    logic [LREG_W-1:0] rd_s;
    rd_s = in_rd;
    in_valid = 1;
    tick();
    clear_beat();
    for (int k = 0; k <= stall; k++) begin
      chk("req_valid", mem_req_valid, 1);
      chk("req_addr", mem_req_addr, exp_addr);
      chk("req_wdata", mem_req_wdata, exp_wdata);
      chk("req_wmask", {56'd0, mem_req_wmask}, {56'd0, exp_mask});
      chk("req_wen", mem_req_wen, exp_wen);
      chk("ready_in_req", in_ready, 0);
      chk("no_wb_in_req", wb_valid, 0);
      if (k == stall) mem_req_ready = 1;
      tick();
    end
    mem_req_ready = 0;
    for (int k = 0; k < lat; k++) begin
      chk("req_dropped", mem_req_valid, 0);
      chk("ready_in_wait", in_ready, 0);
      tick();
    end
    mem_resp_valid = 1;
    mem_resp_rdata = rdata;
    chk("ready_at_resp", in_ready, 0);
    tick();
    mem_resp_valid = 0;
    chk("mem_wb_valid", wb_valid, exp_wb);
    if (exp_wb) begin
      chk("mem_wb_rd", wb_rd, rd_s);
      chk("mem_wb_data", wb_data, exp_data);
    end
    chk("ready_after_resp", in_ready, 1);
    tick();
    chk("mem_wb_pulse_end", wb_valid, 0);
  endtask

  initial begin
    logic [63:0] a, d, r;
    int nb, off, kind;
    bit uns, nw;
    clear_beat();
    reset = 1; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    tick(); tick();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_flush", flush_valid, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    reset = 0;
    tick();
    chk("rst_ready", in_ready, 1);

    // ALU beat, then the same with rd=0
    in_rd = 5; in_alu_result = 64'h1234; in_need_to_wb = 1;
    plain_beat(1, 64'h1234, 0, 0);
    in_rd = 0; in_alu_result = 64'h1234; in_need_to_wb = 1;
    plain_beat(0, 0, 0, 0);

    // Jump with redirect
    clear_beat();
    in_rd = 1; in_need_to_wb = 1; in_is_bju = 1; in_bju_result = 64'h8000_0004;
    in_alu_result = 64'h55; in_redirect_valid = 1; in_redirect_target = 64'h8000_0100;
    plain_beat(1, 64'h8000_0004, 1, 64'h8000_0100);

    // Signed and unsigned byte loads
    clear_beat();
    in_rd = 7; in_need_to_wb = 1; in_is_load = 1; in_ls_size = 4'b0001; in_ls_address = 64'h1003;
    mem_beat(0, 1, 64'h0000_0000_8000_0000, 1, 64'hFFFF_FFFF_FFFF_FF80, 64'h1000, 0, 8'h08, 0);
    in_rd = 7; in_need_to_wb = 1; in_is_load = 1; in_is_unsigned = 1; in_ls_size = 4'b0001;
    in_ls_address = 64'h1003;
    mem_beat(0, 2, 64'h0000_0000_8000_0000, 1, 64'h80, 64'h1000, 0, 8'h08, 0);

    // Half store with a stalled request
    in_rd = 3; in_need_to_wb = 0; in_is_store = 1; in_ls_size = 4'b0010; in_ls_address = 64'h2006;
    in_store_data = 64'hBEEF;
    mem_beat(3, 1, 64'hDEAD, 0, 0, 64'h2000, 64'hBEEF_0000_0000_0000, 8'hC0, 1);

    // Four back-to-back ALU beats
    clear_beat();
    in_need_to_wb = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_rd = LREG_W'(i + 10); in_alu_result = 64'hA000 + 64'(i);
      tick();
      chk("b2b_wb_valid", wb_valid, 1);
      chk("b2b_wb_rd", wb_rd, 64'(i + 10));
      chk("b2b_wb_data", wb_data, 64'hA000 + 64'(i));
      chk("b2b_ready", in_ready, 1);
    end
    in_valid = 0;
    tick();
    chk("b2b_end", wb_valid, 0);

    // Randomized beats against the reference model
    for (int it = 0; it < 80; it++) begin
      clear_beat();
      kind = $urandom_range(0, 3);
      in_rd = LREG_W'($urandom_range(0, 31));
      nw = 1'($urandom_range(0, 3) != 0);
      in_need_to_wb = nw;
      if (kind < 2) begin
        in_is_bju = 1'($urandom_range(0, 1));
        in_is_muldiv = 1'($urandom_range(0, 1));
        in_alu_result = {$urandom, $urandom};
        in_bju_result = {$urandom, $urandom};
        in_muldiv_result = {$urandom, $urandom};
        in_redirect_valid = 1'($urandom_range(0, 1));
        in_redirect_target = {$urandom, $urandom};
        r = in_is_bju ? in_bju_result : (in_is_muldiv ? in_muldiv_result : in_alu_result);
        plain_beat(nw && in_rd != 0, r, in_redirect_valid, in_redirect_target);
      end else begin
        nb = 1 << $urandom_range(0, 3);
        a = {$urandom, $urandom};
        off = int'(a[2:0]);
        d = {$urandom, $urandom};
        r = {$urandom, $urandom};
        uns = 1'($urandom_range(0, 1));
        in_ls_size = size_code(nb); in_ls_address = a; in_store_data = d; in_is_unsigned = uns;
        if (kind == 2) begin
          in_is_load = 1; in_is_store = 1'($urandom_range(0, 1));
          mem_beat($urandom_range(0, 3), $urandom_range(0, 3), r, nw && in_rd != 0,
                   ref_load(r, off, nb, uns), {a[63:3], 3'b000}, ref_wdata(off, d),
                   ref_mask(off, nb), 0);
        end else begin
          in_is_store = 1;
          mem_beat($urandom_range(0, 3), $urandom_range(0, 3), r, 0, 0, {a[63:3], 3'b000},
                   ref_wdata(off, d), ref_mask(off, nb), 1);
        end
      end
    end

    // Reset while waiting for a load response
    clear_beat();
    in_rd = 9; in_need_to_wb = 1; in_alu_result = 64'h77;
    plain_beat(1, 64'h77, 0, 0);
    in_rd = 9; in_need_to_wb = 1; in_is_load = 1; in_ls_size = 4'b1000; in_ls_address = 64'h3000;
    in_valid = 1;
    tick();
    clear_beat();
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    chk("in_wait_ready", in_ready, 0);
    reset = 1;
    #1;
    chk("mid_rst_req_valid", mem_req_valid, 0);
    chk("mid_rst_wb_data", wb_data, 0);
    chk("mid_rst_wb_valid", wb_valid, 0);
    chk("mid_rst_wmask", {56'd0, mem_req_wmask}, 0);
    tick();
    reset = 0;
    tick();
    chk("post_rst_ready", in_ready, 1);
    mem_resp_valid = 1; mem_resp_rdata = 64'h1111;
    tick();
    mem_resp_valid = 0;
    chk("stale_resp_no_wb", wb_valid, 0);
    chk("stale_resp_ready", in_ready, 1);
    tick();
    chk("stale_resp_no_wb2", wb_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
